// File: rtl/cfg_loader_if.sv
// ----------------------------------------------------------------------------
// cfg_loader_if
//
// Purpose: upstream word stream that feeds configuration words into
// cfg_loader. One word moves on every rising clock edge where s_valid and
// s_ready are both high.
//
// Signals:
//   s_valid  source -> loader   word on s_data is valid
//   s_data   source -> loader   32-bit configuration word
//   s_ready  loader -> source   loader takes the word on this edge
//
// Modports:
//   master   word source (drives s_valid/s_data, observes s_ready)
//   slave    cfg_loader (observes s_valid/s_data, drives s_ready)
// ----------------------------------------------------------------------------
interface cfg_loader_if;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/cfg_loader.sv
// ----------------------------------------------------------------------------
// cfg_loader
//
// Purpose: streams N_WORDS configuration words into a serial programming
// chain (a shift register of 32-bit stages). Each accepted word is
// registered and presented on prog_data with a one-cycle prog_shft pulse,
// so the chain captures it on the following edge. After the last word and
// one flush cycle the chain holds the full configuration and done is
// raised; prog_shft then stays low so the decoded routing is live.
//
// Optional feature (macro CFG_READBACK_EN, undefined by default):
//   After the flush cycle the chain is rotated once around its full length
//   (prog_ret fed back into prog_data for N_WORDS cycles). The returned
//   words are summed and compared against the running sum of the loaded
//   words; a mismatch sets the sticky err flag. Without the macro, FLUSH
//   goes straight to DONE, err is tied low and no readback logic exists.
//
// Parameters:
//   N_WORDS    number of 32-bit stages in the chain (1..4096)
//
// Ports:
//   clk        clock, all state updates on its rising edge
//   nres       synchronous active-low reset
//   start      one-cycle request to begin a load (honoured in IDLE/DONE)
//   up         upstream word stream (cfg_loader_if.slave)
//   prog_ret   word returned from the chain's last stage
//   prog_data  word driven into the chain's first stage
//   prog_shft  chain shift enable
//   busy       a load (or its flush/readback) is in progress
//   done       chain holds a complete configuration
//   err        readback sum mismatch, sticky until the next start
// ----------------------------------------------------------------------------
module cfg_loader #(
    parameter int N_WORDS = 75
) (
    input  logic               clk,
    input  logic               nres,
    input  logic               start,
    cfg_loader_if.slave        up,
    input  logic        [31:0] prog_ret,
    output logic        [31:0] prog_data,
    output logic               prog_shft,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // Counter has to reach N_WORDS itself, hence the +1.
    localparam int CW = $clog2(N_WORDS + 1);

    // Counter value at which the current accept (or rotation cycle) is
    // the final one.
    localparam logic [CW-1:0] LAST_IDX = CW'(N_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
`ifdef CFG_READBACK_EN
        S_VERIFY,
`endif
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   count;
    logic [31:0]     data_q;
    logic            shft_q;
    logic            accept;

    // A word moves only while loading; there is no other back-pressure.
    assign up.s_ready = (state == S_LOAD);
    assign accept     = up.s_valid && (state == S_LOAD);

    assign done = (state == S_DONE);
`ifdef CFG_READBACK_EN
    assign busy = (state == S_LOAD) || (state == S_FLUSH) || (state == S_VERIFY);
`else
    assign busy = (state == S_LOAD) || (state == S_FLUSH);
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register in the design samples the pre-edge values together.
        if (!nres) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: the default is assigned before the case so every path
        // through this block writes state_nxt; without it a latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                // start is deliberately not looked at here.
                if (accept && (count == LAST_IDX)) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // One cycle for the final word's shift pulse to reach the chain.
`ifdef CFG_READBACK_EN
                state_nxt = S_VERIFY;
`else
                state_nxt = S_DONE;
`endif
            end
`ifdef CFG_READBACK_EN
            S_VERIFY: begin
                if (count == LAST_IDX) begin
                    state_nxt = S_DONE;
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef CFG_READBACK_EN
    // ------------------------------------------------------------------
    // Datapath with readback: load counter doubles as rotation counter.
    // ------------------------------------------------------------------
    logic [31:0] checksum;
    logic [31:0] rb_sum;
    logic        err_q;

    always_ff @(posedge clk) begin
        if (!nres) begin
            count    <= '0;
            data_q   <= '0;
            shft_q   <= 1'b0;
            checksum <= '0;
            rb_sum   <= '0;
            err_q    <= 1'b0;
        end else begin
            // Shift pulse is one cycle wide unless re-armed by an accept.
            shft_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        count    <= '0;
                        checksum <= '0;
                        err_q    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        data_q   <= up.s_data;
                        shft_q   <= 1'b1;
                        count    <= count + 1'b1;
                        checksum <= checksum + up.s_data;
                    end
                end
                S_FLUSH: begin
                    count  <= '0;
                    rb_sum <= '0;
                end
                S_VERIFY: begin
                    count  <= count + 1'b1;
                    rb_sum <= rb_sum + prog_ret;
                    // Final rotation cycle: include this cycle's word in the
                    // comparison since rb_sum has not absorbed it yet.
                    if (count == LAST_IDX) begin
                        err_q <= ((rb_sum + prog_ret) != checksum);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // During VERIFY the chain's output is looped straight back to its input
    // so that N_WORDS shifts return it to the loaded contents.
    assign prog_shft = (state == S_VERIFY) ? 1'b1     : shft_q;
    assign prog_data = (state == S_VERIFY) ? prog_ret : data_q;
    assign err       = err_q;

`else
    // ------------------------------------------------------------------
    // Datapath without readback
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nres) begin
            count  <= '0;
            data_q <= '0;
            shft_q <= 1'b0;
        end else begin
            // Shift pulse is one cycle wide unless re-armed by an accept.
            shft_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        count <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        data_q <= up.s_data;
                        shft_q <= 1'b1;
                        count  <= count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign prog_shft = shft_q;
    assign prog_data = data_q;
    assign err       = 1'b0;

    // prog_ret only feeds the readback path, which is absent in this build.
    logic unused_prog_ret;
    assign unused_prog_ret = ^prog_ret;
`endif

endmodule

// File: tb/tb_cfg_loader.sv
// ----------------------------------------------------------------------------
// tb_cfg_loader
//
// Drives cfg_loader through reset, back-to-back, gapped, interrupted and
// random loads. A behavioural chain (array of stages shifted on prog_shft)
// sits on the programming port; expected results come from the word list:
// the first word offered ends up in the last stage, one shift pulse per word,
// prog_shft high exactly in the cycle after each accepted word.
// Build with +define+CFG_READBACK_EN to exercise readback (N_WORDS=4).
// ----------------------------------------------------------------------------
module tb_cfg_loader;

`ifdef CFG_READBACK_EN
    localparam int N  = 4;
    localparam int RB = 1;
`else
    localparam int N  = 75;
    localparam int RB = 0;
`endif

    logic        clk   = 1'b0;
    logic        nres  = 1'b0;
    logic        start = 1'b0;
    logic [31:0] prog_ret;
    logic [31:0] prog_data;
    logic        prog_shft;
    logic        busy;
    logic        done;
    logic        err;

    cfg_loader_if bus ();

    cfg_loader #(.N_WORDS(N)) dut (
        .clk       (clk),
        .nres      (nres),
        .start     (start),
        .up        (bus.slave),
        .prog_ret  (prog_ret),
        .prog_data (prog_data),
        .prog_shft (prog_shft),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Programming chain: stage 0 takes prog_data, stage N-1 drives prog_ret.
    // fault_en models stage 2 with bit 0 stuck at 1.
    // ------------------------------------------------------------------
    logic [31:0] chain [N] = '{default: 32'h0};
    int          pulse_cnt = 0;
    bit          fault_en  = 1'b0;

    always @(posedge clk) begin
        if (prog_shft) begin
            for (int i = N - 1; i > 0; i--) begin
                chain[i] <= chain[i-1];
            end
            chain[0] <= prog_data;
            if (fault_en) begin
                chain[2] <= chain[1] | 32'd1;
            end
            pulse_cnt <= pulse_cnt + 1;
        end
    end

    assign prog_ret = chain[N-1];

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int          total = 0;
    int          bad   = 0;
    logic [31:0] wq [$];
    logic [31:0] last_word = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 back-to-back, 1 valid toggling 1/0, 2 random valid.
    // start_at: cycle index in LOAD at which start is pulsed (-1: never).
    // abort_at: reset after this many accepted words (-1: never).
    task automatic run_load(input string name, input int mode,
                            input int start_at, input int abort_at);
        int          idx = 0;
        int          cyc = 0;
        int          base;
        int          mm = 0;
        bit          v;
        logic [31:0] exp_err;

        base  = pulse_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, ":start_busy"},  busy,       1);
        check({name, ":start_ready"}, bus.s_ready, 1);
        check({name, ":start_done"},  done,       0);
        check({name, ":start_err"},   err,        0);

        while (idx < N) begin
            if (cyc >= 4 * N + 50) begin
                check({name, ":timeout_words"}, idx, N);
                bus.s_valid = 1'b0;
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.s_valid = v;
            bus.s_data  = v ? wq[idx] : $urandom;
            start       = (cyc == start_at);
            tick();
            cyc++;
            start = 1'b0;
            if (v) begin
                last_word = wq[idx];
                idx++;
            end
            check({name, ":shft"},  prog_shft,   v);
            check({name, ":data"},  prog_data,   last_word);
            check({name, ":ready"}, bus.s_ready, (idx < N));
            check({name, ":busy"},  busy,        1);
            check({name, ":done"},  done,        0);
            if (v && idx == abort_at) begin
                bus.s_valid = 1'b0;
                nres        = 1'b0;
                tick();
                nres        = 1'b1;
                last_word   = 32'h0;
                check({name, ":rst_busy"},  busy,        0);
                check({name, ":rst_shft"},  prog_shft,   0);
                check({name, ":rst_ready"}, bus.s_ready, 0);
                check({name, ":rst_done"},  done,        0);
                check({name, ":rst_data"},  prog_data,   0);
                return;
            end
        end

        // Now in the flush cycle; offer an extra word that must be refused.
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hDEAD_BEEF;
`ifdef CFG_READBACK_EN
        for (int k = 0; k < N; k++) begin
            tick();
            check({name, ":vfy_busy"},  busy,        1);
            check({name, ":vfy_done"},  done,        0);
            check({name, ":vfy_shft"},  prog_shft,   1);
            check({name, ":vfy_ready"}, bus.s_ready, 0);
        end
        exp_err = {31'h0, fault_en};
`else
        exp_err = 32'h0;
`endif
        tick();
        check({name, ":fin_done"},  done,        1);
        check({name, ":fin_busy"},  busy,        0);
        check({name, ":fin_shft"},  prog_shft,   0);
        check({name, ":fin_ready"}, bus.s_ready, 0);
        check({name, ":fin_data"},  prog_data,   last_word);
        check({name, ":fin_err"},   err,         exp_err);
        tick();
        check({name, ":done_hold"}, done,        1);
        check({name, ":done_shft"}, prog_shft,   0);
        bus.s_valid = 1'b0;
        check({name, ":pulses"}, pulse_cnt - base, (RB + 1) * N);
        if (!fault_en) begin
            for (int i = 0; i < N; i++) begin
                if (chain[i] !== wq[N-1-i]) mm++;
            end
            check({name, ":chain"}, mm, 0);
        end
    endtask

    task automatic fill_seq();
        wq.delete();
        for (int i = 0; i < N; i++) wq.push_back(32'(i));
    endtask

    task automatic fill_rand();
        wq.delete();
        for (int i = 0; i < N; i++) wq.push_back($urandom);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 32'h0;
        nres        = 1'b0;
        repeat (3) tick();
        check("reset:ready", bus.s_ready, 0);
        check("reset:shft",  prog_shft,   0);
        check("reset:data",  prog_data,   0);
        check("reset:busy",  busy,        0);
        check("reset:done",  done,        0);
        check("reset:err",   err,         0);
        nres = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h1234_5678;
        tick();
        check("idle:ready", bus.s_ready, 0);
        check("idle:shft",  prog_shft,   0);
        bus.s_valid = 1'b0;

        // Words 0..N-1 back to back.
        fill_seq();
        run_load("b2b", 0, -1, -1);
        check("b2b:last_stage",  chain[N-1], 0);
        check("b2b:first_stage", chain[0],   N - 1);

        // Gapped load from DONE with a start pulse while loading.
        run_load("toggle", 1, 10, -1);

        // Reset part-way through, then a full load.
        fill_rand();
        run_load("abort", 0, -1, (N > 40) ? 40 : N / 2);
        fill_seq();
        run_load("after_abort", 0, -1, -1);

`ifdef CFG_READBACK_EN
        // Stuck bit in stage 2 with an all-zero configuration.
        wq.delete();
        for (int i = 0; i < N; i++) wq.push_back(32'h0);
        fault_en = 1'b1;
        run_load("fault", 0, -1, -1);
        fault_en = 1'b0;
        wq.delete();
        for (int i = 1; i <= N; i++) wq.push_back(32'(i));
        run_load("rb_clean", 0, -1, -1);
`endif

        for (int r = 0; r < 3; r++) begin
            fill_rand();
            run_load($sformatf("rand%0d", r), 2, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
